// File: rtl/datapath_ctrl_pkg.sv
// Shared types for the datapath sequencer: instruction layout, class codes, FSM states.
// Field order in instr_t mirrors the 36-bit instruction word, MSB first.
package datapath_ctrl_pkg;

  localparam int INSTR_W = 36;
  localparam int SEL_W   = 6;
  localparam int ALUC_W  = 4;
  localparam int SHIFT_W = 2;
  localparam int IMM_W   = 10;
  localparam int KMX_W   = 16;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    CLS_ALU_RR  = 2'b00,
    CLS_ALU_IMM = 2'b01,
    CLS_LOAD    = 2'b10,
    CLS_STORE   = 2'b11
  } instr_class_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM_RD,
    ST_MEM_WB
  } seq_state_e;

  typedef struct packed {
    instr_class_e       cls;
    logic [ALUC_W-1:0]  aluc;
    logic [SHIFT_W-1:0] shift;
    logic [SEL_W-1:0]   a_sel;
    logic [SEL_W-1:0]   b_sel;
    logic [SEL_W-1:0]   c_sel;
    logic [IMM_W-1:0]   imm;
  } instr_t;

  function automatic logic [KMX_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(KMX_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/ctrl_instr_decode.sv
// Combinational split of an instruction word into fields plus the sign-extended immediate.
// Zero latency; no handshake.
module ctrl_instr_decode
  import datapath_ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr,
  output instr_t             o_fields,
  output logic [KMX_W-1:0]   o_kmx
);

  assign o_fields = instr_t'(i_instr);
  assign o_kmx    = sext_imm(o_fields.imm);

endmodule

// File: rtl/datapath_sequencer.sv
// Instruction sequencer driving the ALU/register-bank/shifter datapath; DATAPATH_SEQ_RETIRE_CNT_EN adds o_retire_cnt.
// Latency: ALU/STORE retire 1 cycle after accept, LOAD after MEM_LAT; one instruction in flight, ready only in IDLE.
module datapath_sequencer
  import datapath_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_instr_valid,
  output logic               o_instr_ready,
  input  logic               i_cy_out_dp,
  output logic [SEL_W-1:0]   o_sel_a_rb,
  output logic [SEL_W-1:0]   o_sel_b_rb,
  output logic [SEL_W-1:0]   o_c_sel_rb,
  output logic               o_rb_we,
  output logic [ALUC_W-1:0]  o_aluc_in,
  output logic [SHIFT_W-1:0] o_shifter_sel,
  output logic               o_y_x_kmx_sel,
  output logic [KMX_W-1:0]   o_kmx_out,
  output logic [IMM_W-1:0]   o_mem_addr,
  output logic               o_mr,
  output logic               o_mw,
  output logic               o_cy_in_dp,
`ifdef DATAPATH_SEQ_RETIRE_CNT_EN
  output logic [15:0]        o_retire_cnt,
`endif
  output logic               o_done
);

  seq_state_e           r_state;
  logic [INSTR_W-1:0]   r_instr;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ready, r_carry;
  logic [SEL_W-1:0]     r_sel_a, r_sel_b, r_sel_c;
  logic                 r_rb_we, r_y_sel, r_mr, r_mw, r_done;
  logic [ALUC_W-1:0]    r_aluc;
  logic [SHIFT_W-1:0]   r_shift;
  logic [KMX_W-1:0]     r_kmx;
  logic [IMM_W-1:0]     r_mem_addr;

  logic [INSTR_W-1:0]   w_dec_src;
  instr_t               w_f;
  logic [KMX_W-1:0]     w_kmx;
  logic                 w_is_alu;

  // In IDLE the incoming word is decoded so controls are registered on the accept edge.
  assign w_dec_src = (r_state == ST_IDLE) ? i_instr : r_instr;
  assign w_is_alu  = (w_f.cls == CLS_ALU_RR) || (w_f.cls == CLS_ALU_IMM);

  ctrl_instr_decode u_decode (
    .i_instr  (w_dec_src),
    .o_fields (w_f),
    .o_kmx    (w_kmx)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_instr    <= '0;
      r_cnt      <= '0;
      r_ready    <= 1'b0;
      r_carry    <= 1'b0;
      r_sel_a    <= '0;
      r_sel_b    <= '0;
      r_sel_c    <= '0;
      r_rb_we    <= 1'b0;
      r_y_sel    <= 1'b0;
      r_mr       <= 1'b0;
      r_mw       <= 1'b0;
      r_done     <= 1'b0;
      r_aluc     <= '0;
      r_shift    <= '0;
      r_kmx      <= '0;
      r_mem_addr <= '0;
    end else begin
      r_sel_a    <= '0;
      r_sel_b    <= '0;
      r_sel_c    <= '0;
      r_rb_we    <= 1'b0;
      r_y_sel    <= 1'b0;
      r_mr       <= 1'b0;
      r_mw       <= 1'b0;
      r_done     <= 1'b0;
      r_aluc     <= '0;
      r_shift    <= '0;
      r_kmx      <= '0;
      r_mem_addr <= '0;
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (i_instr_valid && r_ready) begin
            r_instr <= i_instr;
            r_state <= ST_EXEC;
            r_ready <= 1'b0;
            case (w_f.cls)
              CLS_ALU_RR, CLS_ALU_IMM: begin
                r_sel_a <= w_f.a_sel;
                r_sel_b <= w_f.b_sel;
                r_sel_c <= w_f.c_sel;
                r_aluc  <= w_f.aluc;
                r_shift <= w_f.shift;
                r_rb_we <= 1'b1;
                r_done  <= 1'b1;
                if (w_f.cls == CLS_ALU_IMM) begin
                  r_y_sel <= 1'b1;
                  r_kmx   <= w_kmx;
                end
              end
              CLS_LOAD: begin
                r_mr       <= 1'b1;
                r_mem_addr <= w_f.imm;
                r_cnt      <= CNT_W'(MEM_LAT - 1);
                // Single-cycle memory: the EXEC cycle is also the writeback cycle.
                if (MEM_LAT == 1) begin
                  r_rb_we <= 1'b1;
                  r_sel_c <= w_f.c_sel;
                  r_done  <= 1'b1;
                end
              end
              default: begin
                r_sel_a    <= w_f.a_sel;
                r_mem_addr <= w_f.imm;
                r_mw       <= 1'b1;
                r_done     <= 1'b1;
              end
            endcase
          end
        end
        ST_EXEC, ST_MEM_RD: begin
          if (r_state == ST_EXEC && w_f.cls != CLS_LOAD) begin
            if (w_is_alu) r_carry <= i_cy_out_dp;
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end else if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_mr       <= 1'b1;
            r_mem_addr <= w_f.imm;
            r_cnt      <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
              r_state <= ST_MEM_WB;
              r_rb_we <= 1'b1;
              r_sel_c <= w_f.c_sel;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_MEM_RD;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef DATAPATH_SEQ_RETIRE_CNT_EN
  logic [15:0] r_retire_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_retire_cnt <= '0;
    else if (r_done) r_retire_cnt <= r_retire_cnt + 16'd1;
  end

  assign o_retire_cnt = r_retire_cnt;
`endif

  assign o_instr_ready = r_ready;
  assign o_sel_a_rb    = r_sel_a;
  assign o_sel_b_rb    = r_sel_b;
  assign o_c_sel_rb    = r_sel_c;
  assign o_rb_we       = r_rb_we;
  assign o_aluc_in     = r_aluc;
  assign o_shifter_sel = r_shift;
  assign o_y_x_kmx_sel = r_y_sel;
  assign o_kmx_out     = r_kmx;
  assign o_mem_addr    = r_mem_addr;
  assign o_mr          = r_mr;
  assign o_mw          = r_mw;
  assign o_cy_in_dp    = r_carry;
  assign o_done        = r_done;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with MEM_LAT=3; inputs driven and outputs sampled on the falling edge.
module tb_datapath_sequencer;

  logic        clk, rst_n;
  logic [35:0] instr;
  logic        valid, cy_out;
  logic        ready, rb_we, y_sel, mr, mw, cy_in, done;
  logic [5:0]  sel_a, sel_b, sel_c;
  logic [3:0]  aluc;
  logic [1:0]  shsel;
  logic [15:0] kmx;
  logic [9:0]  maddr;
`ifdef DATAPATH_SEQ_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;

  datapath_sequencer #(.MEM_LAT(3)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_instr       (instr),
    .i_instr_valid (valid),
    .o_instr_ready (ready),
    .i_cy_out_dp   (cy_out),
    .o_sel_a_rb    (sel_a),
    .o_sel_b_rb    (sel_b),
    .o_c_sel_rb    (sel_c),
    .o_rb_we       (rb_we),
    .o_aluc_in     (aluc),
    .o_shifter_sel (shsel),
    .o_y_x_kmx_sel (y_sel),
    .o_kmx_out     (kmx),
    .o_mem_addr    (maddr),
    .o_mr          (mr),
    .o_mw          (mw),
    .o_cy_in_dp    (cy_in),
`ifdef DATAPATH_SEQ_RETIRE_CNT_EN
    .o_retire_cnt  (retire_cnt),
`endif
    .o_done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] mk(input logic [1:0] cls, input logic [3:0] fn,
                                     input logic [1:0] sh, input logic [5:0] a,
                                     input logic [5:0] b, input logic [5:0] c,
                                     input logic [9:0] imm);
    return {cls, fn, sh, a, b, c, imm};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    valid  = 1'b0;
    instr  = '0;
    cy_out = 1'b0;
    step();
    step();
    chk("rst_ready_low", ready, 0);
    chk("rst_done", done, 0);
    chk("rst_mr_mw", {mr, mw, rb_we}, 0);
    chk("rst_kmx_addr", {kmx, maddr}, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", ready, 1);
    chk("post_rst_carry", cy_in, 0);
`ifdef DATAPATH_SEQ_RETIRE_CNT_EN
    chk("post_rst_retire", retire_cnt, 0);
`endif

    // ALU_RR, carry out of datapath = 1
    instr = mk(2'b00, 4'h2, 2'b01, 6'd5, 6'd6, 6'd7, 10'h000); valid = 1'b1; cy_out = 1'b1;
    step();
    valid = 1'b0;
    chk("rr_sel_a", sel_a, 5);
    chk("rr_sel_b", sel_b, 6);
    chk("rr_sel_c", sel_c, 7);
    chk("rr_aluc", aluc, 2);
    chk("rr_shift", shsel, 1);
    chk("rr_we_done", {rb_we, done, y_sel, ready}, 4'b1100);
    chk("rr_carry_old", cy_in, 0);
    step();
    chk("rr_carry_new", cy_in, 1);
    chk("rr_after", {rb_we, done, ready}, 3'b001);

    // ALU_IMM negative and positive immediates; carry out 0 then 1
    instr = mk(2'b01, 4'h5, 2'b00, 6'd1, 6'd0, 6'd2, 10'h3FF); valid = 1'b1; cy_out = 1'b0;
    step();
    valid = 1'b0;
    chk("imm_neg_kmx", kmx, 16'hFFFF);
    chk("imm_neg_ysel", {y_sel, rb_we, done}, 3'b111);
    chk("imm_neg_csel", sel_c, 2);
    step();
    chk("imm_neg_carry", cy_in, 0);
    instr = mk(2'b01, 4'h5, 2'b00, 6'd1, 6'd0, 6'd2, 10'h1FF); valid = 1'b1; cy_out = 1'b1;
    step();
    valid = 1'b0;
    chk("imm_pos_kmx", kmx, 16'h01FF);
    chk("imm_pos_ysel", y_sel, 1);
    step();
    chk("imm_pos_carry", cy_in, 1);
    chk("imm_idle_kmx", {kmx, y_sel}, 0);

    // STORE leaves carry at 1 even with carry out 0
    instr = mk(2'b11, 4'h0, 2'b00, 6'd3, 6'd0, 6'd0, 10'h001); valid = 1'b1; cy_out = 1'b0;
    step();
    valid = 1'b0;
    chk("st_mw", mw, 1);
    chk("st_sel_a", sel_a, 3);
    chk("st_addr", maddr, 10'h001);
    chk("st_we_mr", {rb_we, mr}, 0);
    chk("st_done", done, 1);
    step();
    chk("st_mw_off", mw, 0);
    chk("st_carry", cy_in, 1);
    chk("st_ready", ready, 1);

    // LOAD, MEM_LAT=3
    instr = mk(2'b10, 4'h0, 2'b00, 6'd0, 6'd0, 6'd9, 10'h12A); valid = 1'b1;
    step();
    valid = 1'b0;
    chk("ld_c1", {mr, mw, rb_we, done, ready}, 5'b10000);
    chk("ld_c1_addr", maddr, 10'h12A);
    step();
    chk("ld_c2", {mr, mw, rb_we, done, ready}, 5'b10000);
    chk("ld_c2_addr", maddr, 10'h12A);
    step();
    chk("ld_c3", {mr, mw, rb_we, done, ready}, 5'b10110);
    chk("ld_c3_addr", maddr, 10'h12A);
    chk("ld_c3_csel", sel_c, 9);
    step();
    chk("ld_end", {mr, rb_we, done, ready}, 4'b0001);
    chk("ld_carry", cy_in, 1);
`ifdef DATAPATH_SEQ_RETIRE_CNT_EN
    chk("retire_5", retire_cnt, 5);
`endif

    // LOAD aborted by reset during the second MR cycle
    instr = mk(2'b10, 4'h0, 2'b00, 6'd0, 6'd0, 6'd4, 10'h055); valid = 1'b1;
    step();
    valid = 1'b0;
    chk("abort_c1_mr", mr, 1);
    step();
    chk("abort_c2_mr", mr, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {mr, mw, rb_we, done, ready}, 0);
    chk("abort_addr", maddr, 0);
    chk("abort_carry", cy_in, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("abort_ready", ready, 1);
    chk("abort_no_done", {done, rb_we, mr}, 0);

    // Four back-to-back ALU instructions with valid held high
    instr = mk(2'b00, 4'h1, 2'b00, 6'd10, 6'd11, 6'd12, 10'h000); valid = 1'b1; cy_out = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done === 1'b1) n_done++;
      chk($sformatf("b2b_done_%0d", i), done, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("b2b_ready_%0d", i), ready, (i % 2 == 0) ? 0 : 1);
      if (i == 6) valid = 1'b0;
      else if (i % 2 == 0) instr = mk(2'b00, 4'(i + 2), 2'b00, 6'(i), 6'd11, 6'd12, 10'h000);
    end
    chk("b2b_done_count", n_done, 4);
`ifdef DATAPATH_SEQ_RETIRE_CNT_EN
    chk("b2b_retire", retire_cnt, 4);
`endif
    step();
    chk("b2b_idle", {done, ready}, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
